// File: rtl/alarm_pkg.sv
// Shared state encoding, time limits and helpers for the alarm controller.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } alarm_state_t;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;
   localparam int TIMER_W  = 9;

   function automatic logic time_valid(input logic [4:0] hour, input logic [5:0] min);
      return (int'(hour) <= HOUR_MAX) && (int'(min) <= MIN_MAX);
   endfunction

endpackage

// File: rtl/tick_timer.sv
// 9-bit tick counter with synchronous clear; pulses done on the tick that reaches LIMIT.
module tick_timer
   import alarm_pkg::*;
#(
   parameter int LIMIT = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic done
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

   logic [TIMER_W-1:0] count;

   assign done = tick && !clr && (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr || done) begin
         count <= '0;
      end else if (tick) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: arms, rings on a minute match, auto-stops after RING_SEC ticks.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set,
   input  logic [4:0] hour_in,
   input  logic [5:0] min_in,
   input  logic       en,
   input  logic       tick,
   input  logic [4:0] hour_now,
   input  logic [5:0] min_now,
   input  logic [5:0] sec_now,
   input  logic       stop,
   input  logic       snooze,
   output logic       ring,
   output logic [1:0] state,
   output logic [4:0] alarm_hour,
   output logic [5:0] alarm_min
);

   alarm_state_t cur_state, next_state;
   logic         match, ring_done, snooze_done, snooze_req;

   // sec_now==0 lasts a single tick, so a match can fire at most once per minute.
   assign match = tick && (hour_now == alarm_hour) && (min_now == alarm_min) &&
                  (sec_now == 6'd0);

   tick_timer #(.LIMIT(RING_SEC)) u_ring_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (cur_state != ST_RINGING),
      .tick (tick),
      .done (ring_done)
   );

`ifdef ALARM_SNOOZE_EN
   assign snooze_req = snooze;

   tick_timer #(.LIMIT(SNOOZE_SEC)) u_snooze_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (cur_state != ST_SNOOZE),
      .tick (tick),
      .done (snooze_done)
   );
`else
   logic unused_snooze;
   assign unused_snooze = snooze ^ (SNOOZE_SEC == 0);
   assign snooze_req    = 1'b0;
   assign snooze_done   = 1'b0;
`endif

   // NOTE: next_state gets its default first so no path through this block infers a latch.
   always_comb begin
      next_state = cur_state;
      if (!en) begin
         next_state = ST_OFF;
      end else if (set) begin
         next_state = ST_ARMED;
      end else if (stop && (cur_state == ST_RINGING || cur_state == ST_SNOOZE)) begin
         next_state = ST_ARMED;
      end else if (snooze_req && cur_state == ST_RINGING) begin
         next_state = ST_SNOOZE;
      end else begin
         case (cur_state)
            ST_OFF:     next_state = ST_ARMED;
            ST_ARMED:   if (match)       next_state = ST_RINGING;
            ST_RINGING: if (ring_done)   next_state = ST_ARMED;
            ST_SNOOZE:  if (snooze_done) next_state = ST_RINGING;
            default:    next_state = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state  <= ST_OFF;
         ring       <= 1'b0;
         alarm_hour <= '0;
         alarm_min  <= '0;
      end else begin
         cur_state <= next_state;
         ring      <= (next_state == ST_RINGING);
         if (set && time_valid(hour_in, min_in)) begin
            alarm_hour <= hour_in;
            alarm_min  <= min_in;
         end
      end
   end

   assign state = cur_state;

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60, ring duration in ticks before auto-stop, legal range 1..511.
REQ-002 Parameter SNOOZE_SEC, default 300, snooze delay in ticks before re-ring, legal range 1..511.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 set  input  1  load alarm time from hour_in/min_in on this edge.
REQ-006 hour_in  input  5  alarm hour to load, binary 0..23.
REQ-007 min_in  input  6  alarm minute to load, binary 0..59.
REQ-008 en  input  1  alarm armed when 1; alarm off when 0.
REQ-009 tick  input  1  one-clock pulse per second, same pulse that advances the watch counter.
REQ-010 hour_now / min_now / sec_now  input  5/6/6  current watch time from the watch counter.
REQ-011 stop  input  1  silence alarm.
REQ-012 snooze  input  1  postpone ring by SNOOZE_SEC ticks.
REQ-013 ring  output  1  buzzer drive, registered.
REQ-014 state  output  2  current FSM state: OFF=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-015 alarm_hour / alarm_min  output  5/6  stored alarm time.

Function
REQ-016 FSM SHALL have states OFF, ARMED, RINGING, SNOOZE; next-state priority: en=0 > set > stop > snooze > timeout/match.
REQ-017 en=0 SHALL force OFF and ring=0 on the next edge from any state; OFF with en=1 SHALL go to ARMED on the next edge.
REQ-018 set=1 SHALL load alarm_hour<=hour_in, alarm_min<=min_in only when hour_in<=23 and min_in<=59; out-of-range loads are ignored and the stored time is kept.
REQ-019 set=1 in RINGING or SNOOZE SHALL go to ARMED (en=1) with ring=0 and both timers cleared.
REQ-020 Match SHALL be tick=1 and hour_now==alarm_hour and min_now==alarm_min and sec_now==0; in ARMED, match SHALL go to RINGING on that edge, giving ring=1 one clock after the matching tick.
REQ-021 Match SHALL be ignored in OFF, RINGING, and SNOOZE; because sec_now==0 is present for only one tick, the alarm SHALL fire at most once per matching minute.
REQ-022 In RINGING, the ring timer SHALL count ticks from 0; on the tick that reaches RING_SEC, the FSM SHALL return to ARMED with ring=0.
REQ-023 stop=1 in RINGING or SNOOZE SHALL return to ARMED with ring=0 on the next edge; stop in OFF/ARMED has no effect.
REQ-024 snooze=1 in RINGING SHALL go to SNOOZE with ring=0 and the snooze timer cleared; in SNOOZE, on the tick that reaches SNOOZE_SEC, the FSM SHALL go to RINGING with the ring timer cleared.
REQ-025 Timers SHALL advance only on tick=1 and SHALL be 9 bits wide; non-tick cycles hold them.
REQ-026 stop and snooze asserted together SHALL resolve as stop.

Reset
REQ-027 rst=0 SHALL immediately set state=OFF, ring=0, alarm_hour=0, alarm_min=0, and both timers to 0, regardless of clk.
REQ-028 Reset deassertion mid-ring SHALL leave the FSM in OFF; a match in the first cycle after release is ignored.

Configuration
REQ-029 Macro ALARM_SNOOZE_EN defined: SNOOZE state, snooze timer, and snooze input are functional as in REQ-024.
REQ-030 Macro ALARM_SNOOZE_EN undefined: snooze input is ignored, SNOOZE is unreachable, state never reads 3, and the snooze timer is not built.

Structure
REQ-031 Package alarm_pkg SHALL hold the state encoding constants and time limits HOUR_MAX=23 and MIN_MAX=59.
REQ-032 Both timers SHALL be instances of one sub-module, tick_timer (9-bit, clear, tick-enable, terminal-count pulse at a parameter limit).

Verification
REQ-033 Reset pulse, then en=1 -> state OFF then ARMED; ring=0; alarm time 0:00.
REQ-034 set with 7:30, watch at 7:29:59, tick -> sec_now=0 at 7:30:00, next tick -> ring=1 one clock after that tick; with RING_SEC=5, ring=0 after the 5th further tick.
REQ-035 set with 24:10 and with 5:60 -> alarm time unchanged, no ring at the following match.
REQ-036 Ringing, snooze=1 with SNOOZE_SEC=3 -> ring=0, state=3; after 3 ticks -> ring=1; stop=1 -> ARMED, ring=0.
REQ-037 Ringing, en=0 together with stop=1 and snooze=1 -> OFF next edge; build without ALARM_SNOOZE_EN -> snooze ignored, ring stays 1.
REQ-038 Asynchronous rst=0 between clock edges while ringing -> ring=0 and state=0 immediately.
